// File: rtl/seg_pattern_reader.sv
// rtl/seg_pattern_reader.sv - 7-segment bus reader: stability-qualified decode to per-digit nibbles
// Recovers hex digits from a multiplexed segment bus and reports changes on a valid/ready port.
module seg_pattern_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int IDX_W         = 2,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   digit_ok,
  output logic                    upd_valid,
  input  logic                    upd_ready,
  output logic [IDX_W-1:0]        upd_idx,
  output logic [3:0]              upd_nibble,
  output logic                    upd_blank,
  output logic                    upd_err,
  output logic                    overflow,
  input  logic                    clr_ovf
);

  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

  // {valid, nibble}; unknown patterns give nibble 0
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F: decode = 5'h10;
      7'h06: decode = 5'h11;
      7'h5B: decode = 5'h12;
      7'h4F: decode = 5'h13;
      7'h66: decode = 5'h14;
      7'h6D: decode = 5'h15;
      7'h7D: decode = 5'h16;
      7'h07: decode = 5'h17;
      7'h7F: decode = 5'h18;
      7'h67: decode = 5'h19;
      7'h77: decode = 5'h1A;
      7'h7C: decode = 5'h1B;
      7'h39: decode = 5'h1C;
      7'h5E: decode = 5'h1D;
      7'h79: decode = 5'h1E;
      7'h71: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  state_t                state;
  logic [6:0]            seg_r;
  logic [NUM_DIGITS-1:0] en_r;
  logic [NUM_DIGITS-1:0] cur_en;
  logic [IDX_W-1:0]      cur_idx;
  logic [6:0]            cur_pat;
  logic [7:0]            cnt;
  logic [6:0]            last_pat [NUM_DIGITS];

  logic [IDX_W-1:0] enc_idx;
  logic             one_hot;
  logic [7:0]       cnt_next;
  logic             at_target;
  logic             restart;
  logic             c_commit;
  logic [IDX_W-1:0] c_idx;
  logic [6:0]       c_pat;
  logic [4:0]       dec;
  logic             eff;
  logic             emit_ok;

  always_comb begin
    enc_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (en_r[i]) enc_idx = IDX_W'(i);
  end

  assign one_hot   = $onehot(en_r);
  assign cnt_next  = cnt + 8'd1;
  assign at_target = (cnt_next == 8'(STABLE_CYCLES));
  // any bus change outside TRACK's own pattern reload restarts the window as if idle
  assign restart   = (state == IDLE) || (en_r != cur_en) ||
                     ((state == HOLD) && (seg_r != cur_pat));

  always_comb begin
    c_commit = 1'b0;
    c_idx    = cur_idx;
    c_pat    = cur_pat;
    if (restart) begin
      if (one_hot && STABLE_CYCLES == 1) begin
        c_commit = 1'b1;
        c_idx    = enc_idx;
        c_pat    = seg_r;
      end
    end else if (state == TRACK) begin
      if (seg_r == cur_pat) begin
        c_commit = at_target;
      end else if (STABLE_CYCLES == 1) begin
        c_commit = 1'b1;
        c_pat    = seg_r;
      end
    end
  end

  assign dec     = decode(c_pat);
  assign eff     = c_commit && (c_pat != last_pat[c_idx]);
  assign emit_ok = !upd_valid || upd_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      seg_r      <= '0;
      en_r       <= '0;
      cur_en     <= '0;
      cur_idx    <= '0;
      cur_pat    <= '0;
      cnt        <= '0;
      value      <= '0;
      digit_ok   <= '0;
      upd_valid  <= 1'b0;
      upd_idx    <= '0;
      upd_nibble <= '0;
      upd_blank  <= 1'b0;
      upd_err    <= 1'b0;
      overflow   <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) last_pat[i] <= '0;
    end else begin
      seg_r <= seg_in;
      en_r  <= dig_en;

      if (restart) begin
        if (one_hot) begin
          cur_en  <= en_r;
          cur_idx <= enc_idx;
          cur_pat <= seg_r;
          cnt     <= 8'd1;
          state   <= (STABLE_CYCLES == 1) ? HOLD : TRACK;
        end else begin
          cnt   <= '0;
          state <= IDLE;
        end
      end else if (state == TRACK) begin
        if (seg_r == cur_pat) begin
          cnt <= cnt_next;
          if (at_target) state <= HOLD;
        end else begin
          cur_pat <= seg_r;
          cnt     <= 8'd1;
          if (STABLE_CYCLES == 1) state <= HOLD;
        end
      end

      // digit state follows every effective commit even when the event is dropped
      if (eff) begin
        last_pat[c_idx] <= c_pat;
        digit_ok[c_idx] <= dec[4];
        if (dec[4]) value[{c_idx, 2'b00} +: 4] <= dec[3:0];
      end

      if (eff && emit_ok) begin
        upd_valid  <= 1'b1;
        upd_idx    <= c_idx;
        upd_nibble <= dec[3:0];
        upd_blank  <= (c_pat == 7'h00);
        upd_err    <= !dec[4] && (c_pat != 7'h00);
      end else if (upd_valid && upd_ready) begin
        upd_valid <= 1'b0;
      end

      if (eff && !emit_ok) overflow <= 1'b1;
      else if (clr_ovf)    overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_pattern_reader.sv
// tb/tb_seg_pattern_reader.sv - directed self-checking bench for seg_pattern_reader
module tb_seg_pattern_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  seg_in;
  logic [3:0]  dig_en;
  logic [15:0] value;
  logic [3:0]  digit_ok;
  logic        upd_valid;
  logic        upd_ready;
  logic [1:0]  upd_idx;
  logic [3:0]  upd_nibble;
  logic        upd_blank;
  logic        upd_err;
  logic        overflow;
  logic        clr_ovf;

  int checks = 0;
  int errors = 0;

  logic [6:0] pats [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg_pattern_reader #(.NUM_DIGITS(4), .IDX_W(2), .STABLE_CYCLES(3)) dut (
    .clk(clk), .reset_n(reset_n), .seg_in(seg_in), .dig_en(dig_en),
    .value(value), .digit_ok(digit_ok), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_idx(upd_idx), .upd_nibble(upd_nibble), .upd_blank(upd_blank), .upd_err(upd_err),
    .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic consume();
    upd_ready = 1'b1;
    tick(1);
    upd_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; seg_in = 7'h7F; dig_en = 4'b0001; upd_ready = 1'b0; clr_ovf = 1'b0;
    tick(3);
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_digit_ok", 32'(digit_ok), 32'h0);
    chk("rst_valid", 32'(upd_valid), 32'h0);
    chk("rst_payload", {24'h0, upd_idx, upd_nibble, upd_blank, upd_err}, 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    reset_n = 1'b1; dig_en = 4'b0000; seg_in = 7'h00;
    tick(6);
    chk("post_rst_no_event", 32'(upd_valid), 32'h0);

    dig_en = 4'b0010; seg_in = 7'h4F;
    tick(3);
    chk("t2_not_yet", 32'(upd_valid), 32'h0);
    tick(1);
    chk("t2_valid", 32'(upd_valid), 32'h1);
    chk("t2_payload", {24'h0, upd_idx, upd_nibble, upd_blank, upd_err}, {24'h0, 2'd1, 4'h3, 2'b00});
    chk("t2_value", 32'(value), 32'h0030);
    chk("t2_digit_ok", 32'(digit_ok), 32'b0010);
    tick(2);
    consume();
    chk("t2_consumed", 32'(upd_valid), 32'h0);
    dig_en = 4'b0000;
    tick(2);
    dig_en = 4'b0010;
    tick(6);
    chk("t2_repeat_no_event", 32'(upd_valid), 32'h0);
    chk("t2_repeat_value", 32'(value), 32'h0030);

    dig_en = 4'b0001; seg_in = 7'h06;
    tick(2);
    seg_in = 7'h5B;
    tick(3);
    chk("t3_no_event_for_1", 32'(upd_valid), 32'h0);
    tick(1);
    chk("t3_valid", 32'(upd_valid), 32'h1);
    chk("t3_payload", {24'h0, upd_idx, upd_nibble, upd_blank, upd_err}, {24'h0, 2'd0, 4'h2, 2'b00});
    chk("t3_value", 32'(value), 32'h0032);
    chk("t3_digit_ok", 32'(digit_ok), 32'b0011);
    consume();

    seg_in = 7'h01;
    tick(4);
    chk("t4_err_valid", 32'(upd_valid), 32'h1);
    chk("t4_err_payload", {24'h0, upd_idx, upd_nibble, upd_blank, upd_err}, {24'h0, 2'd0, 4'h0, 2'b01});
    chk("t4_err_digit_ok", 32'(digit_ok), 32'b0010);
    chk("t4_err_value_kept", 32'(value), 32'h0032);
    consume();
    seg_in = 7'h00;
    tick(4);
    chk("t4_blank_valid", 32'(upd_valid), 32'h1);
    chk("t4_blank_payload", {24'h0, upd_idx, upd_nibble, upd_blank, upd_err}, {24'h0, 2'd0, 4'h0, 2'b10});
    chk("t4_blank_value_kept", 32'(value), 32'h0032);
    consume();

    seg_in = 7'h3F;
    tick(4);
    chk("t5_first_valid", 32'(upd_valid), 32'h1);
    seg_in = 7'h06;
    tick(4);
    chk("t5_held_payload", {24'h0, upd_idx, upd_nibble, upd_blank, upd_err}, {24'h0, 2'd0, 4'h0, 2'b00});
    chk("t5_overflow_set", 32'(overflow), 32'h1);
    chk("t5_value_updated", 32'(value), 32'h0031);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    chk("t5_overflow_clr", 32'(overflow), 32'h0);
    seg_in = 7'h5B;
    tick(3);
    upd_ready = 1'b1;
    tick(1);
    upd_ready = 1'b0;
    chk("t5_coincident_valid", 32'(upd_valid), 32'h1);
    chk("t5_coincident_nibble", 32'(upd_nibble), 32'h2);
    chk("t5_coincident_no_ovf", 32'(overflow), 32'h0);
    consume();

    dig_en = 4'b1000;
    for (int i = 0; i < 16; i++) begin
      seg_in = pats[i];
      tick(4);
      chk($sformatf("t6_sweep_%0d", i), {26'h0, upd_valid, upd_idx, upd_err, upd_blank, 1'b0} | 32'(upd_nibble) << 8,
          {26'h0, 1'b1, 2'd3, 2'b00, 1'b0} | 32'(i) << 8);
      consume();
    end
    chk("t6_value", 32'(value), 32'hF032);
    dig_en = 4'b0011; seg_in = 7'h3F;
    tick(6);
    chk("t6_multihot_no_event", 32'(upd_valid), 32'h0);
    chk("t6_multihot_value", 32'(value), 32'hF032);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
